// File: rtl/plic_pkg.sv
// Shared register map and gateway state encoding for the lite interrupt arbiter.
// Latency: none (constants and types only); backpressure: n/a.
package plic_pkg;

    localparam logic [9:0] PLIC_PRIO_BASE = 10'h000;
    localparam logic [9:0] PLIC_PENDING   = 10'h080;
    localparam logic [9:0] PLIC_ENABLE    = 10'h100;
    localparam logic [9:0] PLIC_THRESHOLD = 10'h200;
    localparam logic [9:0] PLIC_CLAIM     = 10'h204;

    typedef enum logic [1:0] {
        GW_IDLE    = 2'b00,
        GW_PENDING = 2'b01,
        GW_CLAIMED = 2'b10
    } gw_state_t;

endpackage

// File: rtl/plic_gateway.sv
// Per-source gateway: latches a level request and holds it through claim/complete.
// Latency: 1 cycle src -> pending; backpressure: src ignored unless IDLE.
module plic_gateway
    import plic_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic src,
    input  logic claim_hit,
    input  logic complete_hit,
    output logic pending,
    output logic claimed
);

    gw_state_t state, state_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= GW_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            GW_IDLE:    if (src)          state_next = GW_PENDING;
            GW_PENDING: if (claim_hit)    state_next = GW_CLAIMED;
            GW_CLAIMED: if (complete_hit) state_next = GW_IDLE;
            default:                      state_next = GW_IDLE;
        endcase
    end

    assign pending = (state == GW_PENDING);
    assign claimed = (state == GW_CLAIMED);

endmodule

// File: rtl/plic_lite.sv
// Interrupt arbiter: gateways, priority/enable/threshold registers, claim/complete port.
// Latency: bus ack 1 cycle, irq 1 cycle after arbitration; backpressure: none, one access at a time.
module plic_lite
    import plic_pkg::*;
#(
    parameter int N_SRC  = 8,
    parameter int PRIO_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_SRC-1:0]  src_i,
    input  logic              bus_req_i,
    input  logic              bus_we_i,
    input  logic [9:0]        bus_addr_i,
    input  logic [31:0]       bus_wdata_i,
    output logic [31:0]       bus_rdata_o,
    output logic              bus_ack_o,
    output logic              external_interrupt_o
);

    logic [9:0]        addr;
    logic              rd, wr, claim_rd, complete_wr;
    logic [PRIO_W-1:0] prio [1:N_SRC];
    logic [N_SRC:1]    enable;
    logic [PRIO_W-1:0] threshold;
    logic [N_SRC-1:0]  pending, claimed, claim_hit, complete_hit;
    logic [4:0]        winner;
    logic [PRIO_W-1:0] best_prio;
    logic [31:0]       rdata_next;
    logic              unused_bits;

    assign addr        = {bus_addr_i[9:2], 2'b00};
    assign rd          = bus_req_i && !bus_we_i;
    assign wr          = bus_req_i && bus_we_i;
    assign claim_rd    = rd && (addr == PLIC_CLAIM);
    assign complete_wr = wr && (addr == PLIC_CLAIM);
    assign unused_bits = ^{bus_addr_i[1:0], bus_wdata_i};

    for (genvar i = 1; i <= N_SRC; i++) begin : g_src
        assign claim_hit[i-1]    = claim_rd && (winner == 5'(i));
        assign complete_hit[i-1] = complete_wr && (bus_wdata_i[4:0] == 5'(i)) && claimed[i-1];

        plic_gateway u_gw (
            .clk          (clk),
            .rst          (rst),
            .src          (src_i[i-1]),
            .claim_hit    (claim_hit[i-1]),
            .complete_hit (complete_hit[i-1]),
            .pending      (pending[i-1]),
            .claimed      (claimed[i-1])
        );
    end

    // Seeding best_prio with the threshold folds "prio > threshold" into the search;
    // strict compare while scanning upward keeps ties on the lowest ID.
    always_comb begin
        best_prio = threshold;
        winner    = 5'd0;
        for (int i = 1; i <= N_SRC; i++) begin
            if (pending[i-1] && enable[i] && (prio[i] > best_prio)) begin
                best_prio = prio[i];
                winner    = 5'(i);
            end
        end
    end

    always_comb begin
        rdata_next = '0;
        for (int i = 1; i <= N_SRC; i++) begin
            if (addr == PLIC_PRIO_BASE + 10'(4 * i)) rdata_next[PRIO_W-1:0] = prio[i];
        end
        case (addr)
            PLIC_PENDING:   rdata_next[N_SRC:1]    = pending;
            PLIC_ENABLE:    rdata_next[N_SRC:1]    = enable;
            PLIC_THRESHOLD: rdata_next[PRIO_W-1:0] = threshold;
            PLIC_CLAIM:     rdata_next[4:0]        = winner;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i <= N_SRC; i++) prio[i] <= '0;
            enable               <= '0;
            threshold            <= '0;
            bus_ack_o            <= 1'b0;
            bus_rdata_o          <= '0;
            external_interrupt_o <= 1'b0;
        end else begin
            bus_ack_o            <= bus_req_i;
            bus_rdata_o          <= rd ? rdata_next : '0;
            external_interrupt_o <= (winner != 5'd0);
            if (wr) begin
                for (int i = 1; i <= N_SRC; i++) begin
                    if (addr == PLIC_PRIO_BASE + 10'(4 * i)) prio[i] <= bus_wdata_i[PRIO_W-1:0];
                end
                if (addr == PLIC_ENABLE)    enable    <= bus_wdata_i[N_SRC:1];
                if (addr == PLIC_THRESHOLD) threshold <= bus_wdata_i[PRIO_W-1:0];
            end
        end
    end

endmodule
